// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to 4-digit BCD converter, one bit per clock.
// Optional BIN2BCD_CLAMP_EN: saturate bcd to 9999 on overflow instead of keeping the low four digits.
module bin2bcd_seq #(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bcd,
    output logic            ovf,
    output logic            valid
);
    localparam int CW = $clog2(IN_W);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [19:0]     scratch;
    logic [IN_W-1:0] operand;
    logic [19:0]     adj;
    logic [19:0]     nxt;
    logic            ovf_n;
    logic [15:0]     bcd_n;
    always_comb begin
        adj = '0;
        for (int d = 0; d < 5; d++)
            adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3 : scratch[4*d +: 4];
        nxt   = {adj[18:0], operand[IN_W-1]};
        ovf_n = |nxt[19:16];
`ifdef BIN2BCD_CLAMP_EN
        bcd_n = ovf_n ? 16'h9999 : nxt[15:0];
`else
        bcd_n = nxt[15:0];
`endif
    end
    assign busy = (state == SHIFT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            scratch <= '0;
            operand <= '0;
            bcd     <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        operand <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= nxt;
                    operand <= operand << 1;
                    cnt     <= cnt + 1'b1;
                    // last operand bit shifted in: publish result on this same edge
                    if (cnt == CW'(IN_W - 1)) begin
                        bcd   <= bcd_n;
                        ovf   <= ovf_n;
                        done  <= 1'b1;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table-driven checks of bin2bcd_seq plus directed multi-cycle corner cases.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic        busy, done, ovf, valid;
    logic [15:0] bcd;
    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.IN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] b;
        logic [15:0] eb;
        logic        eo;
    } vec_t;

`ifdef BIN2BCD_CLAMP_EN
    localparam logic [15:0] OV65535 = 16'h9999;
    localparam logic [15:0] OV10000 = 16'h9999;
    localparam logic [15:0] OV12345 = 16'h9999;
`else
    localparam logic [15:0] OV65535 = 16'h5535;
    localparam logic [15:0] OV10000 = 16'h0000;
    localparam logic [15:0] OV12345 = 16'h2345;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input logic [15:0] b, input logic [15:0] eb, input logic eo, input string nm);
        int nb, lat, chg;
        bit found;
        logic [15:0] prev;
        prev = bcd;
        bin = b;
        start = 1'b1;
        step();
        start = 1'b0;
        nb = 0; lat = 0; chg = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done) begin
                found = 1;
                lat = i;
            end else begin
                if (busy) nb++;
                if (bcd !== prev) chg++;
                step();
            end
        end
        chk({nm, "_done_seen"}, found, 1);
        chk({nm, "_latency"}, lat, 16);
        chk({nm, "_busy_cycles"}, nb, 16);
        chk({nm, "_bcd_stable_in_shift"}, chg, 0);
        chk({nm, "_bcd"}, bcd, eb);
        chk({nm, "_ovf"}, ovf, eo);
        chk({nm, "_valid"}, valid, 1);
        step();
        chk({nm, "_done_one_cycle"}, done, 0);
        chk({nm, "_bcd_hold"}, bcd, eb);
        chk({nm, "_idle_not_busy"}, busy, 0);
    endtask

    initial begin
        vec_t vt[10];
        int t, d1, d2, ndone, tdone;
        vt[0] = '{16'h04D2, 16'h1234, 1'b0};
        vt[1] = '{16'd0,     16'h0000, 1'b0};
        vt[2] = '{16'd9999,  16'h9999, 1'b0};
        vt[3] = '{16'd10000, OV10000,  1'b1};
        vt[4] = '{16'd65535, OV65535,  1'b1};
        vt[5] = '{16'd42,    16'h0042, 1'b0};
        vt[6] = '{16'd1,     16'h0001, 1'b0};
        vt[7] = '{16'd9000,  16'h9000, 1'b0};
        vt[8] = '{16'd12345, OV12345,  1'b1};
        vt[9] = '{16'd5678,  16'h5678, 1'b0};

        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_bcd", bcd, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_valid", valid, 0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) conv(vt[i].b, vt[i].eb, vt[i].eo, $sformatf("vec%0d", i));

        // back-to-back: start held through DONE
        bin = 16'd9999;
        start = 1'b1;
        step();
        t = 0; d1 = -1; d2 = -1;
        while (t < 60 && d2 < 0) begin
            if (done && d1 < 0) begin
                d1 = t;
                chk("b2b_first_bcd", bcd, 16'h9999);
                bin = 16'd0;
            end else if (done) begin
                d2 = t;
                chk("b2b_second_bcd", bcd, 16'h0000);
            end
            if (d1 >= 0 && t == d1 + 1) chk("b2b_no_idle_busy", busy, 1);
            if (d1 >= 0 && t == d1 + 1) start = 1'b0;
            if (d2 < 0) step();
            t++;
        end
        chk("b2b_first_latency", d1, 16);
        chk("b2b_spacing", d2 - d1, 17);
        step();
        chk("b2b_then_idle", busy, 0);

        // start pulses during SHIFT must be ignored
        bin = 16'd42;
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0; tdone = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ndone++;
                if (tdone < 0) tdone = i;
                chk("ignore_bcd", bcd, 16'h0042);
            end
            if (i == 2 || i == 8) begin
                bin = 16'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        chk("ignore_single_done", ndone, 1);
        chk("ignore_latency", tdone, 16);

        // async reset mid-SHIFT
        bin = 16'd5555;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_bcd", bcd, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_valid", valid, 0);
        step();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            step();
        end
        chk("arst_no_done", ndone, 0);
        chk("arst_bcd_held", bcd, 0);
        chk("arst_valid_held", valid, 0);
        conv(16'd2024, 16'h2024, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: IN_W, 16, binary input width; legal range 14..16.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  conversion request, sampled on rising clk.
REQ-005 Port: bin  input  IN_W  unsigned binary value, captured on accepted start.
REQ-006 Port: busy  output  1  high while conversion in progress.
REQ-007 Port: done  output  1  one-cycle pulse marking new result on bcd/ovf.
REQ-008 Port: bcd  output  16  four packed BCD digits, [3:0] ones .. [15:12] thousands; feeds the downstream 4-digit display value input.
REQ-009 Port: ovf  output  1  last converted bin exceeded 9999.
REQ-010 Port: valid  output  1  sticky; high once any conversion completes; drives display enable.

Function
REQ-011 Sequential double-dabble, one bin bit per clock, MSB first; internal scratch 20 bits (5 digits).
REQ-012 States: IDLE, SHIFT, DONE; state register only, no combinational loops.
REQ-013 start accepted only in IDLE or DONE; on accepting edge k: bin latched, scratch cleared, bit counter = 0, state -> SHIFT.
REQ-014 start while in SHIFT ignored; latched operand and progress unaffected.
REQ-015 SHIFT step per edge: every scratch digit >= 5 gets +3, then {scratch, operand} shifts left 1.
REQ-016 Final (IN_W-th) step at edge k+IN_W; same edge registers bcd, ovf, sets done, sets valid, state -> DONE.
REQ-017 Latency: result on bcd exactly IN_W clocks after accepting edge; done high for the one cycle following edge k+IN_W.
REQ-018 busy = 1 exactly in SHIFT (IN_W cycles); 0 in IDLE and DONE.
REQ-019 DONE -> IDLE on next edge unless start high, then DONE -> SHIFT (back-to-back, no dead cycle).
REQ-020 ovf = 1 when bin > 9999 (fifth scratch digit non-zero), else 0.
REQ-021 bcd and ovf hold between done pulses; never change during SHIFT.
REQ-022 Boundaries: bin=0 -> bcd 0x0000, ovf 0; bin=9999 -> 0x9999, ovf 0; bin=10000 -> overflow handling per REQ-026.

Reset
REQ-023 rst high forces immediately, independent of clk: state IDLE, busy 0, done 0, bcd 0x0000, ovf 0, valid 0, scratch and counter 0.
REQ-024 rst during SHIFT aborts conversion; no done pulse; bcd stays 0x0000 until a new conversion completes.
REQ-025 First start accepted on first rising clk with rst low.

Configuration
REQ-026 Macro BIN2BCD_CLAMP_EN: defined -> on overflow bcd = 0x9999; undefined -> bcd = low four digits (bin mod 10000); ovf = 1 in both cases.

Verification
REQ-027 rst, then start with bin=0x04D2 -> busy 16 cycles, done pulse 16 clocks after start edge, bcd=0x1234, ovf=0, valid=1.
REQ-028 bin=9999 then bin=0 back-to-back (start held through DONE) -> bcd 0x9999 then 0x0000, no idle cycle, two done pulses 17 clocks apart.
REQ-029 bin=65535 -> ovf=1; bcd=0x9999 with BIN2BCD_CLAMP_EN, 0x5535 without; bin=10000 -> 0x9999 / 0x0000.
REQ-030 start pulses at cycles 3 and 9 after accepting bin=42 with bin=7 -> second ignored; single done, bcd=0x0042.
REQ-031 rst asserted mid-SHIFT at cycle 8 -> all outputs 0 immediately, no done; subsequent bin=2024 -> bcd=0x2024.
